shifter_seq: RTL

Multi-cycle, parametrised shift/rotate unit for the execute stage. It replaces a fixed single-stage 16-bit logical-right shift with a WIDTH-generic unit supporting four modes. It resolves one binary shift stage per clock under a valid/ready handshake on both sides. The ALU issues an operand, amount and mode, then waits for the result while the pipeline stalls on in_ready/out_valid.

---
 rtl/shifter_seq.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/shifter_seq.sv
// -----------------------------------------------------------------------------
// shifter_seq -- multi-cycle shift/rotate unit for the execute stage.
//
// Resolves one binary shift stage (by 2^k) per clock. An operand, amount and
// mode are accepted in IDLE, worked on in SHIFT, and the result is presented in
// DONE until the consumer takes it.
//
// Parameters:
//   WIDTH       data width, power of two, >= 2 (default 16)
//   AW          $clog2(WIDTH), derived; shift-amount width and stage count
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   in_valid    request present
//   in_ready    unit idle and able to accept
//   in_data     operand [WIDTH-1:0]
//   in_amt      shift amount [AW-1:0]
//   in_mode     00 ROL, 01 SLL, 10 ROR, 11 SRL
//   out_valid   result available
//   out_ready   consumer takes result
//   out_data    result [WIDTH-1:0]
//
// Build option:
//   SHIFTER_SKIP_EN  when defined, stages whose amount bit is zero are skipped,
//                    so latency becomes popcount(amt) cycles after acceptance.
//                    Results are identical to the default build.
// -----------------------------------------------------------------------------
module shifter_seq #(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_amt,
    input  logic [1:0]                 in_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data
);

    localparam int AW = $clog2(WIDTH);
    // Width of the stage index: just enough bits to address every amount bit.
    localparam int KW = (AW > 1) ? $clog2(AW) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  work_q,  work_d;
    logic [AW-1:0]     amt_q,   amt_d;
    logic [1:0]        mode_q,  mode_d;
    logic [KW-1:0]     k_q,     k_d;

    // One stage of the barrel: move data by 2^k in the given mode. Rotates use
    // a doubled copy of the operand so the wrapped bits fall out of the shift.
    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] data,
        input logic [1:0]       mode,
        input logic [KW-1:0]    k
    );
        logic [2*WIDTH-1:0] dd;
        logic [2*WIDTH-1:0] tmp;
        logic [WIDTH-1:0]   res;
        int unsigned        s;
        s   = 32'd1 << k;
        dd  = {data, data};
        tmp = '0;
        res = '0;
        case (mode)
            2'b00: begin
                tmp = dd << s;
                res = tmp[2*WIDTH-1:WIDTH];
            end
            2'b01: res = data << s;
            2'b10: begin
                tmp = dd >> s;
                res = tmp[WIDTH-1:0];
            end
            default: res = data >> s;
        endcase
        return res;
    endfunction

`ifdef SHIFTER_SKIP_EN
    // Lowest set bit of amt strictly above position lo. Returns {found, index}.
    function automatic logic [KW:0] first_set_above(
        input logic [AW-1:0] amt,
        input int            lo
    );
        logic          found;
        logic [KW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        // Scan downward so the lowest qualifying bit is the one left standing.
        for (int i = AW - 1; i >= 0; i--) begin
            if (amt[i] && (i > lo)) begin
                found = 1'b1;
                idx   = KW'(i);
            end
        end
        return {found, idx};
    endfunction

    logic [KW:0] nxt;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = work_q;

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        amt_d   = amt_q;
        mode_d  = mode_q;
        k_d     = k_q;
`ifdef SHIFTER_SKIP_EN
        nxt     = '0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d = in_data;
                    amt_d  = in_amt;
                    mode_d = in_mode;
`ifdef SHIFTER_SKIP_EN
                    nxt = first_set_above(in_amt, -1);
                    if (nxt[KW]) begin
                        k_d     = nxt[KW-1:0];
                        state_d = SHIFT;
                    end else begin
                        // Nothing to shift: result is the operand as latched.
                        k_d     = '0;
                        state_d = DONE;
                    end
`else
                    k_d     = '0;
                    state_d = SHIFT;
`endif
                end
            end
            SHIFT: begin
                if (amt_q[k_q]) begin
                    work_d = shift_stage(work_q, mode_q, k_q);
                end
`ifdef SHIFTER_SKIP_EN
                nxt = first_set_above(amt_q, int'(k_q));
                if (nxt[KW]) begin
                    k_d = nxt[KW-1:0];
                end else begin
                    state_d = DONE;
                end
`else
                k_d = k_q + 1'b1;
                if (k_q == KW'(AW - 1)) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            amt_q   <= '0;
            mode_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            amt_q   <= amt_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
        end
    end

endmodule
